ncl_wavefront_ctrl: RTL

- Clocked controller that acts as the synchronous end of the dual-rail NCL adder datapath.
- Sender side: encodes single-rail binary operands into dual-rail DATA wavefronts and drives them into the NCL adder.
- Collector side: completion-detects and decodes the dual-rail result, presents it on a valid/ready interface, then drives the NULL wavefront and waits for the datapath to return to all-NULL.
- Used as the interface between synchronous test/system logic and the 4-bit dual-rail adder and its wider variants.

---
 rtl/ncl_wavefront_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ncl_wavefront_ctrl.sv
// rtl/ncl_wavefront_ctrl.sv - synchronous DATA/NULL wavefront controller for a dual-rail NCL adder
module ncl_wavefront_ctrl #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_cin,
  output logic [2*W-1:0] dr_a,
  output logic [2*W-1:0] dr_b,
  output logic [1:0]     dr_cin,
  input  logic [2*W-1:0] dr_soma,
  input  logic [1:0]     dr_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_soma,
  output logic           out_cout,
  output logic           err_illegal,
  output logic           err_timeout
);

  localparam int RW = 2*W + 2;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_HOLD, S_NULL} state_t;

  state_t        state, state_next;
  logic [RW-1:0] sync_q [SYNC_STAGES];
  logic [RW-1:0] rv;
  logic [W-1:0]  rail1;
  logic [15:0]   cnt;
  logic          complete, allnull, illegal, timed_out, accept;

  function automatic logic [2*W-1:0] encode(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  // Result rails are asynchronous to clk; every decision below uses the synchronized copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {dr_cout, dr_soma};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rv = sync_q[SYNC_STAGES-1];

  always_comb begin
    complete = 1'b1;
    illegal  = 1'b0;
    rail1    = '0;
    for (int i = 0; i <= W; i++) begin
      if (rv[2*i] == rv[2*i+1]) complete = 1'b0;
      if (rv[2*i] && rv[2*i+1]) illegal = 1'b1;
    end
    for (int i = 0; i < W; i++) rail1[i] = rv[2*i+1];
  end

  assign allnull   = (rv == '0);
  assign timed_out = (cnt >= 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid && allnull) state_next = S_DATA;
      S_DATA: begin
        if (illegal)        state_next = S_NULL;
        else if (complete)  state_next = S_HOLD;
        else if (timed_out) state_next = S_NULL;
      end
      S_HOLD: if (out_valid && out_ready) state_next = S_NULL;
      S_NULL: if (allnull) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE) && allnull;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_a        <= '0;
      dr_b        <= '0;
      dr_cin      <= '0;
      out_valid   <= 1'b0;
      out_soma    <= '0;
      out_cout    <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          dr_a   <= encode(in_a);
          dr_b   <= encode(in_b);
          dr_cin <= {in_cin, ~in_cin};
          cnt    <= '0;
        end
        S_DATA: begin
          // Illegal beats complete, which beats the timeout.
          if (illegal) begin
            err_illegal <= 1'b1;
            dr_a <= '0; dr_b <= '0; dr_cin <= '0;
            cnt  <= '0;
          end else if (complete) begin
            out_soma  <= rail1;
            out_cout  <= rv[2*W+1];
            out_valid <= 1'b1;
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            dr_a <= '0; dr_b <= '0; dr_cin <= '0;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_HOLD: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          dr_a <= '0; dr_b <= '0; dr_cin <= '0;
          cnt  <= '0;
        end
        S_NULL: if (!allnull) begin
          if (timed_out) err_timeout <= 1'b1;
          if (cnt != 16'(TIMEOUT)) cnt <= cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
